sc_statemachine_players: RTL
============================

// Module: sc_statemachine_players
// PURPOSE
//  Parametrised multi-player move controller for the board game datapath.
//  - One move FSM per player turns active-low buttons into one-cycle shift commands for that player's shift register.
//  - Adds hold-to-repeat (auto-repeat) and left+right conflict rejection.
//  - A shared start/clear sequencer drives the common active-low clear.
// PARAMETERS
//  NPLAYERS       2    number of players / independent move FSMs (1..8)
//  REPEAT_EN      1    1 = auto-repeat while a direction button is held; 0 = one pulse per press
//  REPEAT_DELAY   4    cycles from first shift pulse to second pulse while held (>=2)
//  REPEAT_PERIOD  2    cycles between subsequent repeat pulses (>=2)
//  CNT_W          $clog2(max(REPEAT_DELAY,REPEAT_PERIOD))+1   repeat counter width
// PORTS
//  SC_STATEMACHINE_PLAYERS_CLOCK_50                 in   1    system clock
//  SC_STATEMACHINE_PLAYERS_RESET_InLow              in   1    asynchronous reset, active low
//  SC_STATEMACHINE_PLAYERS_startButton_InLow        in   1    shared start button, 0 = pressed
//  SC_STATEMACHINE_PLAYERS_leftButton_InLow         in   NPLAYERS  per-player left button, 0 = pressed
//  SC_STATEMACHINE_PLAYERS_rightButton_InLow        in   NPLAYERS  per-player right button, 0 = pressed
//  SC_STATEMACHINE_PLAYERS_leftcomparator_InLow     in   NPLAYERS  1 = room to move left, 0 = at left edge
//  SC_STATEMACHINE_PLAYERS_rightcomparator_InLow    in   NPLAYERS  1 = room to move right, 0 = at right edge
//  SC_STATEMACHINE_PLAYERS_clear_OutLow             out  1    shared clear, 0 = clear
//  SC_STATEMACHINE_PLAYERS_shiftselection_Out       out  2*NPLAYERS  player p at [2p+1:2p]
//                                                          11 = hold, 01 = left, 10 = right, 00 never driven
// BEHAVIOUR
//  - Reset (async, RESET_InLow=0):
//    - clear_OutLow=1; every shiftselection field=2'b11.
//    - All FSMs go to their RESET state; repeat counters go to 0.
//    - Takes effect immediately, including mid-HOLD or mid-CLEAR.
//  - Outputs are decoded combinationally from registered state only (Moore).
//    - A press sampled at clock edge k gives its output during cycle k..k+1 (one-edge latency).
//  - Start sequencer states: RESET -> IDLE (unconditional, 1 cycle).
//    - IDLE: start=0 -> CLEAR.
//    - CLEAR: clear_OutLow=0 for exactly 1 cycle -> START_HOLD.
//    - START_HOLD: stays while start=0; start=1 -> IDLE.
//    - Signal inhibit = (sequencer != IDLE).
//  - Per-player FSM states: CHECK, LEFT, RIGHT, HOLD, WAIT_REL.
//    - CHECK (out 11):
//      - inhibit -> WAIT_REL.
//      - left=0 & right=1 & leftcmp=1 -> LEFT.
//      - right=0 & left=1 & rightcmp=1 -> RIGHT.
//      - Both pressed -> stay in CHECK (conflict rejected, no pulse).
//      - Pressed toward an edge (cmp=0) -> WAIT_REL.
//    - LEFT/RIGHT: output 01/10 for exactly 1 cycle -> HOLD.
//      - On the first pulse of a press the counter is loaded so the next pulse comes REPEAT_DELAY cycles later.
//      - On repeat pulses it is loaded for REPEAT_PERIOD.
//      - The held direction is remembered.
//    - HOLD (out 11): counter decrements each cycle.
//      - Held button released -> CHECK. The other button is ignored.
//      - inhibit -> WAIT_REL.
//      - Counter expiry with REPEAT_EN=1, button still held and cmp=1 -> same direction pulse.
//      - Counter expiry with cmp=0 -> reload REPEAT_PERIOD, no pulse.
//      - REPEAT_EN=0 -> wait for release only.
//    - WAIT_REL (out 11): both buttons of that player released and inhibit=0 -> CHECK.
//  - Players are fully independent; simultaneous events on different players are all honoured in the same cycle.
//  - Counter never wraps: it saturates at 0 until reloaded.
// STRUCTURE
//  - Shared package sc_game_pkg:
//    - shift encodings SHIFT_HOLD=2'b11, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10
//    - start-sequencer and move-FSM state localparams
//  - Sub-module sc_player_movefsm, generated NPLAYERS times:
//    - inputs: buttons, comparators, inhibit
//    - output: 2-bit shift field
//    - parameters: REPEAT_EN, REPEAT_DELAY, REPEAT_PERIOD, CNT_W
//  - The start sequencer lives in the top module.
// TESTING (NPLAYERS=2, REPEAT_DELAY=4, REPEAT_PERIOD=2)
//  1. Reset asserted then released, no buttons -> clear=1, shiftselection=4'b1111 throughout; reset mid-HOLD -> 4'b1111 within same cycle.
//  2. P0 left=0 for 1 cycle, leftcmp=1 -> exactly one cycle of shiftselection=4'b1101, then 4'b1111.
//  3. P1 right held 12 cycles, rightcmp=1 -> [3:2]=10 at cycles t, t+4, t+6, t+8, t+10; with REPEAT_EN=0 only at t.
//  4. P0 left=0 and right=0 in same cycle -> no pulse while both held; release right -> one 01 pulse.
//  5. P0 left held with leftcmp=0 -> no pulse; leftcmp->1 while still held -> still no pulse until release and re-press.
//  6. Start pressed while P1 in HOLD -> clear=0 exactly 1 cycle, all fields 11; P1 moves again only after buttons released and start released.

Source files
------------

// File: rtl/sc_game_pkg.sv
// rtl/sc_game_pkg.sv - shared encodings and state types for the board game move controller
package sc_game_pkg;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        SEQ_RESET      = 2'd0,
        SEQ_IDLE       = 2'd1,
        SEQ_CLEAR      = 2'd2,
        SEQ_START_HOLD = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        MV_CHECK    = 3'd0,
        MV_LEFT     = 3'd1,
        MV_RIGHT    = 3'd2,
        MV_HOLD     = 3'd3,
        MV_WAIT_REL = 3'd4
    } mv_state_t;

    function automatic logic [1:0] mv_shift_code(input mv_state_t s);
        case (s)
            MV_LEFT:  return SHIFT_LEFT;
            MV_RIGHT: return SHIFT_RIGHT;
            default:  return SHIFT_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/sc_player_movefsm.sv
// rtl/sc_player_movefsm.sv - per-player move FSM: button presses to one-cycle shift
// commands, with hold-to-repeat and left+right conflict rejection
import sc_game_pkg::*;

module sc_player_movefsm #(
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 4,
    parameter int REPEAT_PERIOD = 2,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_n,
    input  logic       right_n,
    input  logic       left_room,
    input  logic       right_room,
    input  logic       inhibit,
    output logic [1:0] shift
);

    // The counter is loaded in the pulse cycle and a repeat fires when it reads 1,
    // so loading N-1 places the next pulse exactly N cycles after the current one.
    localparam logic [CNT_W-1:0] LOAD_DELAY  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] LOAD_PERIOD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

    mv_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             first_q, first_d;
    logic             held_n;
    logic             held_room;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MV_CHECK;
            cnt_q   <= CNT_ZERO;
            dir_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            first_q <= first_d;
        end
    end

    // dir_q: 0 = left, 1 = right
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        first_d   = first_q;
        held_n    = dir_q ? right_n : left_n;
        held_room = dir_q ? right_room : left_room;
        case (state_q)
            MV_CHECK: begin
                if (inhibit) begin
                    state_d = MV_WAIT_REL;
                end else if (!left_n && right_n) begin
                    if (left_room) begin
                        state_d = MV_LEFT;
                        dir_d   = 1'b0;
                        first_d = 1'b1;
                    end else begin
                        state_d = MV_WAIT_REL;
                    end
                end else if (!right_n && left_n) begin
                    if (right_room) begin
                        state_d = MV_RIGHT;
                        dir_d   = 1'b1;
                        first_d = 1'b1;
                    end else begin
                        state_d = MV_WAIT_REL;
                    end
                end
            end
            MV_LEFT, MV_RIGHT: begin
                cnt_d   = first_q ? LOAD_DELAY : LOAD_PERIOD;
                state_d = MV_HOLD;
            end
            MV_HOLD: begin
                cnt_d = (cnt_q != CNT_ZERO) ? cnt_q - CNT_ONE : CNT_ZERO;
                if (held_n) begin
                    state_d = MV_CHECK;
                end else if (inhibit) begin
                    state_d = MV_WAIT_REL;
                end else if ((REPEAT_EN != 0) && (cnt_q <= CNT_ONE)) begin
                    if (held_room) begin
                        state_d = dir_q ? MV_RIGHT : MV_LEFT;
                        first_d = 1'b0;
                    end else begin
                        cnt_d = LOAD_PERIOD;
                    end
                end
            end
            MV_WAIT_REL: begin
                if (left_n && right_n && !inhibit) begin
                    state_d = MV_CHECK;
                end
            end
            default: state_d = MV_CHECK;
        endcase
    end

    always_comb begin
        shift = mv_shift_code(state_q);
    end

endmodule

// File: rtl/sc_statemachine_players.sv
// rtl/sc_statemachine_players.sv - multi-player move controller: shared start/clear
// sequencer plus one move FSM per player
import sc_game_pkg::*;

module sc_statemachine_players #(
    parameter int NPLAYERS      = 2,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 4,
    parameter int REPEAT_PERIOD = 2,
    parameter int CNT_W         =
        $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1
) (
    input  logic                  SC_STATEMACHINE_PLAYERS_CLOCK_50,
    input  logic                  SC_STATEMACHINE_PLAYERS_RESET_InLow,
    input  logic                  SC_STATEMACHINE_PLAYERS_startButton_InLow,
    input  logic [NPLAYERS-1:0]   SC_STATEMACHINE_PLAYERS_leftButton_InLow,
    input  logic [NPLAYERS-1:0]   SC_STATEMACHINE_PLAYERS_rightButton_InLow,
    input  logic [NPLAYERS-1:0]   SC_STATEMACHINE_PLAYERS_leftcomparator_InLow,
    input  logic [NPLAYERS-1:0]   SC_STATEMACHINE_PLAYERS_rightcomparator_InLow,
    output logic                  SC_STATEMACHINE_PLAYERS_clear_OutLow,
    output logic [2*NPLAYERS-1:0] SC_STATEMACHINE_PLAYERS_shiftselection_Out
);

    seq_state_t seq_q, seq_d;
    logic       inhibit;

    always_ff @(posedge SC_STATEMACHINE_PLAYERS_CLOCK_50 or
                negedge SC_STATEMACHINE_PLAYERS_RESET_InLow) begin
        if (!SC_STATEMACHINE_PLAYERS_RESET_InLow) begin
            seq_q <= SEQ_RESET;
        end else begin
            seq_q <= seq_d;
        end
    end

    always_comb begin
        seq_d = seq_q;
        case (seq_q)
            SEQ_RESET: seq_d = SEQ_IDLE;
            SEQ_IDLE: begin
                if (!SC_STATEMACHINE_PLAYERS_startButton_InLow) begin
                    seq_d = SEQ_CLEAR;
                end
            end
            SEQ_CLEAR: seq_d = SEQ_START_HOLD;
            SEQ_START_HOLD: begin
                if (SC_STATEMACHINE_PLAYERS_startButton_InLow) begin
                    seq_d = SEQ_IDLE;
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    // Players are frozen whenever the sequencer is anywhere but IDLE.
    always_comb begin
        SC_STATEMACHINE_PLAYERS_clear_OutLow = (seq_q != SEQ_CLEAR);
        inhibit                              = (seq_q != SEQ_IDLE);
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        sc_player_movefsm #(
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_movefsm (
            .clk       (SC_STATEMACHINE_PLAYERS_CLOCK_50),
            .rst_n     (SC_STATEMACHINE_PLAYERS_RESET_InLow),
            .left_n    (SC_STATEMACHINE_PLAYERS_leftButton_InLow[p]),
            .right_n   (SC_STATEMACHINE_PLAYERS_rightButton_InLow[p]),
            .left_room (SC_STATEMACHINE_PLAYERS_leftcomparator_InLow[p]),
            .right_room(SC_STATEMACHINE_PLAYERS_rightcomparator_InLow[p]),
            .inhibit   (inhibit),
            .shift     (SC_STATEMACHINE_PLAYERS_shiftselection_Out[2*p+1:2*p])
        );
    end

endmodule
